posit_encoder_rnd: RTL and testbench

- Pipelined posit<16,1> encoder and rounder. Sits directly downstream of the posit adder.
- Consumes the adder's unpacked result fields: sign, scale factor, fraction, guard, sticky, not-zero/NaR flag.
- Produces the final N-bit posit word, rounded to nearest even.
- Two register stages with a valid/ready handshake on both sides, so it stalls cleanly under back-pressure.

---
 rtl/posit_encoder_rnd.sv | 105 ++++++++++
 tb/tb_posit_encoder_rnd.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder_rnd.sv
// Two-stage posit<16,1> encoder/rounder: stage 1 builds the regime/exponent/fraction
// body, stage 2 rounds to nearest even, clamps to minpos/maxpos and packs the sign.
module posit_encoder_rnd #(
  parameter int N = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_s,
  input  logic [N-10:0]  i_sf,
  input  logic [N-5:0]   i_mant,
  input  logic           i_guard,
  input  logic           i_sticky,
  input  logic           i_nzn,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [N-1:0]   o_posit
);

  localparam int SFW = N - 9;
  localparam int MW  = N - 4;
  localparam int BW  = N - 1;
  localparam int TW  = 2 * N;

  logic              s1_valid;
  logic              s1_s, s1_nzn, s1_sat_hi, s1_sat_lo, s1_rb, s1_stk;
  logic [BW-1:0]     s1_kept;
  logic              s2_advance;

  logic signed [SFW-1:0] t, k;
  logic [SFW-1:0]    run;
  logic              neg;
  logic [TW-1:0]     tail, fill, body;
  logic              sat_hi, sat_lo;

  logic              inc;
  logic [N-1:0]      r16;
  logic [BW-1:0]     r_body;
  logic [N-1:0]      posit_nx;

  assign s2_advance = ~o_valid | i_ready;
  assign o_ready    = ~s1_valid | s2_advance;

  // Regime terminator sits at the top of the tail; shifting right by the run
  // length and back-filling with the run bit yields the left-justified body.
  always_comb begin
    t      = $signed(i_sf ^ {SFW{i_s}});
    k      = t >>> 1;
    neg    = k[SFW-1];
    sat_hi = (k >= 7'sd14);
    sat_lo = (k <= -7'sd15);
    run    = neg ? $unsigned(-k) : $unsigned(k + 7'sd1);
    tail   = {neg, t[0], i_mant, i_guard, {(TW-MW-3){1'b0}}};
    fill   = neg ? '0 : ~({TW{1'b1}} >> run);
    body   = (tail >> run) | fill;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_s      <= 1'b0;
      s1_nzn    <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_kept   <= '0;
      s1_rb     <= 1'b0;
      s1_stk    <= 1'b0;
    end else begin
      if (o_ready) s1_valid <= i_valid;
      if (i_valid && o_ready) begin
        s1_s      <= i_s;
        s1_nzn    <= i_nzn;
        s1_sat_hi <= sat_hi;
        s1_sat_lo <= sat_lo;
        s1_kept   <= body[TW-1 -: BW];
        s1_rb     <= body[TW-1-BW];
        s1_stk    <= i_sticky | (|body[TW-2-BW:0]);
      end
    end
  end

  always_comb begin
    inc = s1_rb & (s1_kept[0] | s1_stk);
    r16 = {1'b0, s1_kept} + {{BW{1'b0}}, inc};
    if (r16[BW] || s1_sat_hi)
      r_body = '1;
    else if ((r16[BW-1:0] == '0) || s1_sat_lo)
      r_body = {{(BW-1){1'b0}}, 1'b1};
    else
      r_body = r16[BW-1:0];
    posit_nx = s1_nzn ? {s1_s, r_body} : {s1_s, {BW{1'b0}}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_posit <= '0;
    end else if (s2_advance) begin
      o_valid <= s1_valid;
      if (s1_valid) o_posit <= posit_nx;
    end
  end

endmodule

// File: tb/tb_posit_encoder_rnd.sv
// Bench for posit_encoder_rnd: directed cases, back-pressure, reset mid-flight,
// then randomized traffic scored against an arithmetic posit<16,1> model.
module tb_posit_encoder_rnd;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, o_ready, i_s, i_guard, i_sticky, i_nzn, o_valid, i_ready;
  logic [6:0]  i_sf;
  logic [11:0] i_mant;
  logic [15:0] o_posit;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  posit_encoder_rnd #(.N(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_s(i_s), .i_sf(i_sf), .i_mant(i_mant), .i_guard(i_guard),
    .i_sticky(i_sticky), .i_nzn(i_nzn), .o_valid(o_valid),
    .i_ready(i_ready), .o_posit(o_posit)
  );

  always #5 i_clk = ~i_clk;

  // Value-level model: regime as an integer run of bits, body as a plain number.
  function automatic logic [15:0] model_enc(input logic s, input logic [6:0] sf,
                                            input logic [11:0] mant, input logic g,
                                            input logic st, input logic nzn);
    int t, e, k, rlen, len;
    longint regime, bodyv, kept, rb, rest;
    if (!nzn) return s ? 16'h8000 : 16'h0000;
    t = int'($signed(sf));
    if (s) t = -t - 1;
    e = t & 1;
    k = (t - e) / 2;
    if (k >= 14) return {s, 15'h7FFF};
    if (k <= -15) return {s, 15'h0001};
    if (k >= 0) begin
      regime = ((64'd1 << (k + 1)) - 1) << 1;
      rlen   = k + 2;
    end else begin
      regime = 1;
      rlen   = -k + 1;
    end
    bodyv = (((regime * 2 + e) * 4096 + mant) * 2) + g;
    len   = rlen + 14;
    kept  = bodyv >> (len - 15);
    rb    = (bodyv >> (len - 16)) & 1;
    rest  = bodyv & ((64'd1 << (len - 16)) - 1);
    if (rb == 1 && ((kept & 1) == 1 || st || rest != 0)) kept = kept + 1;
    if (kept >= 32768) kept = 32767;
    if (kept == 0) kept = 1;
    return {s, kept[14:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: handshakes are evaluated at the falling edge, inputs change after the rise.
  task automatic tick();
    logic [15:0] e;
    @(negedge i_clk);
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", o_posit, 16'hxxxx);
      else begin
        e = exp_q.pop_front();
        chk("scoreboard", o_posit, e);
      end
    end
    if (i_valid && o_ready)
      exp_q.push_back(model_enc(i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn));
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [6:0] sf, input logic [11:0] m,
                        input logic g, input logic st, input logic nzn);
    i_s = s; i_sf = sf; i_mant = m; i_guard = g; i_sticky = st; i_nzn = nzn;
  endtask

  task automatic send(input logic s, input logic [6:0] sf, input logic [11:0] m,
                      input logic g, input logic st, input logic nzn);
    int n = 0;
    set_in(s, sf, m, g, st, nzn);
    i_valid = 1'b1;
    while (!o_ready && n < 20) begin tick(); n++; end
    if (!o_ready) chk("send_timeout", 16'd0, 16'd1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic s, input logic [6:0] sf,
                         input logic [11:0] m, input logic g, input logic st,
                         input logic nzn, input logic [15:0] expv);
    send(s, sf, m, g, st, nzn);
    chk({tag, "_lat1_valid"}, {15'd0, o_valid}, 16'd0);
    tick();
    chk({tag, "_lat2_valid"}, {15'd0, o_valid}, 16'd1);
    chk(tag, o_posit, expv);
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    set_in(1'b0, 7'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_posit", o_posit, 16'h0000);
    chk("rst_ready", {15'd0, o_ready}, 16'd1);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;

    run_one("one",      1'b0, 7'd0,         12'h000, 1'b0, 1'b0, 1'b1, 16'h4000);
    run_one("neg_one",  1'b1, 7'h7F,        12'h000, 1'b0, 1'b0, 1'b1, 16'hC000);
    run_one("zero",     1'b0, 7'd5,         12'h123, 1'b1, 1'b1, 1'b0, 16'h0000);
    run_one("nar",      1'b1, 7'd5,         12'h123, 1'b1, 1'b1, 1'b0, 16'h8000);
    run_one("tie_up",   1'b0, 7'd0,         12'h001, 1'b1, 1'b0, 1'b1, 16'h4002);
    run_one("tie_even", 1'b0, 7'd0,         12'h000, 1'b1, 1'b0, 1'b1, 16'h4000);
    run_one("above_tie",1'b0, 7'd0,         12'h000, 1'b1, 1'b1, 1'b1, 16'h4001);
    run_one("sat_hi",   1'b0, 7'd40,        12'h000, 1'b0, 1'b0, 1'b1, 16'h7FFF);
    run_one("sat_lo",   1'b0, 7'(-40),      12'h000, 1'b0, 1'b0, 1'b1, 16'h0001);
    run_one("near_max", 1'b0, 7'd27,        12'hFFF, 1'b1, 1'b0, 1'b1, 16'h7FFF);
    run_one("sat_hi_neg",1'b1,7'(-41),      12'h000, 1'b0, 1'b0, 1'b1, 16'hFFFF);

    // Back-pressure: two results queued while the consumer stalls.
    i_ready = 1'b0;
    send(1'b0, 7'd0, 12'h000, 1'b0, 1'b0, 1'b1);
    send(1'b1, 7'h7F, 12'h000, 1'b0, 1'b0, 1'b1);
    chk("bp_ready_low", {15'd0, o_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", {15'd0, o_valid}, 16'd1);
      chk("bp_hold_posit", o_posit, 16'h4000);
      tick();
    end
    i_ready = 1'b1;
    tick();
    chk("bp_second_valid", {15'd0, o_valid}, 16'd1);
    chk("bp_second_posit", o_posit, 16'hC000);
    tick();
    chk("bp_drained", {15'd0, o_valid}, 16'd0);

    // Reset with both stages occupied.
    i_ready = 1'b0;
    send(1'b0, 7'd3, 12'hABC, 1'b0, 1'b0, 1'b1);
    send(1'b0, 7'd4, 12'h555, 1'b1, 1'b0, 1'b1);
    chk("mid_full_valid", {15'd0, o_valid}, 16'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", {15'd0, o_valid}, 16'd0);
    chk("mid_rst_posit", o_posit, 16'h0000);
    chk("mid_rst_ready", {15'd0, o_ready}, 16'd1);
    exp_q.delete();
    @(negedge i_clk); i_rst = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_idle", {15'd0, o_valid}, 16'd0);
      tick();
    end

    // Randomized traffic with random stalls on both sides.
    for (int i = 0; i < 3000; i++) begin
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 7);
      set_in(1'($urandom), 7'($urandom), 12'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 9) != 0));
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
